// File: rtl/range_enc_pkg.sv
// Shared constants and types for the range rule stage encoder.
package range_enc_pkg;
    localparam int CW     = 4;
    localparam int STAGES = 4;
    localparam int W      = CW * STAGES;
    localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam int SIG_PREFIX_EQ    = 3;
    localparam int SIG_LB_TAIL_ZERO = 2;
    localparam int SIG_UB_TAIL_MAX  = 1;
    localparam int SIG_LAST         = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;
endpackage

// File: rtl/range_sig_gen.sv
// Per-stage signature: prefix equality above the stage, lb/ub tail shape below it.
module range_sig_gen
    import range_enc_pkg::*;
(
    input  logic [W-1:0]     lb,
    input  logic [W-1:0]     ub,
    input  logic [STG_W-1:0] stage,
    output logic [3:0]       sig
);
    // Packed element STAGES-1 is the MSB chunk, i.e. stage 0.
    logic [STAGES-1:0][CW-1:0] lb_c, ub_c;
    assign lb_c = lb;
    assign ub_c = ub;

    always_comb begin
        sig                   = '0;
        sig[SIG_PREFIX_EQ]    = 1'b1;
        sig[SIG_LB_TAIL_ZERO] = 1'b1;
        sig[SIG_UB_TAIL_MAX]  = 1'b1;
        for (int j = 0; j < STAGES; j++) begin
            if (STG_W'(j) < stage) begin
                if (lb_c[STAGES-1-j] != ub_c[STAGES-1-j])
                    sig[SIG_PREFIX_EQ] = 1'b0;
            end else if (STG_W'(j) > stage) begin
                if (lb_c[STAGES-1-j] != '0)
                    sig[SIG_LB_TAIL_ZERO] = 1'b0;
                if (ub_c[STAGES-1-j] != '1)
                    sig[SIG_UB_TAIL_MAX] = 1'b0;
            end
        end
        sig[SIG_LAST] = (stage == STG_W'(STAGES - 1));
    end
endmodule

// File: rtl/range_stage_encoder.sv
// Splits a [lb, ub] range rule into MSB-first per-stage chunk beats with signatures.
module range_stage_encoder
    import range_enc_pkg::*;
#(
    parameter int IDW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_lb,
    input  logic [W-1:0]     in_ub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [STG_W-1:0] out_stage,
    output logic [CW-1:0]    out_lbs,
    output logic [CW-1:0]    out_ubs,
    output logic [3:0]       out_sig,
    output logic             out_last,
    output logic [IDW-1:0]   out_id,
    output logic             err
);
    state_e                    state_q, state_d;
    logic [STG_W-1:0]          stage_q;
    logic [IDW-1:0]            id_q;
    logic [STAGES-1:0][CW-1:0] lb_q, ub_q;
    logic                      err_q;
    logic                      accept, bad_range, beat_fire, last_stage;
    logic [3:0]                sig;

    assign accept     = in_valid & in_ready;
    assign bad_range  = (in_lb > in_ub);
    assign beat_fire  = out_valid & out_ready;
    assign last_stage = (stage_q == STG_W'(STAGES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !bad_range) state_d = EMIT;
            EMIT:    if (beat_fire && last_stage) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            id_q    <= '0;
            lb_q    <= '0;
            ub_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & bad_range;
            if (accept) begin
                lb_q    <= in_lb;
                ub_q    <= in_ub;
                stage_q <= '0;
            end
            if (beat_fire) begin
                if (last_stage) id_q <= id_q + 1'b1;
                else            stage_q <= stage_q + 1'b1;
            end
        end
    end

    range_sig_gen u_sig (
        .lb    (lb_q),
        .ub    (ub_q),
        .stage (stage_q),
        .sig   (sig)
    );

    // Data outputs read as zero whenever no beat is presented.
    assign out_stage = out_valid ? stage_q : '0;
    assign out_lbs   = out_valid ? lb_q[STG_W'(STAGES - 1) - stage_q] : '0;
    assign out_ubs   = out_valid ? ub_q[STG_W'(STAGES - 1) - stage_q] : '0;
    assign out_sig   = out_valid ? sig : '0;
    assign out_last  = out_sig[SIG_LAST];
    assign out_id    = out_valid ? id_q : '0;
    assign err       = err_q;
endmodule

// File: tb/tb_range_stage_encoder.sv
// Directed plus randomized bench for range_stage_encoder against an arithmetic range model.
module tb_range_stage_encoder;
    localparam int CW     = 4;
    localparam int STAGES = 4;
    localparam int W      = CW * STAGES;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, out_last, err;
    logic [W-1:0]  in_lb, in_ub;
    logic [1:0]    out_stage;
    logic [CW-1:0] out_lbs, out_ubs;
    logic [3:0]    out_sig;
    logic [7:0]    out_id;

    int errs = 0, checks = 0, cyc = 0, model_id = 0;

    range_stage_encoder #(.IDW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_lb(in_lb), .in_ub(in_ub),
        .out_valid(out_valid), .out_ready(out_ready), .out_stage(out_stage),
        .out_lbs(out_lbs), .out_ubs(out_ubs), .out_sig(out_sig),
        .out_last(out_last), .out_id(out_id), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: chunk s counted from the MSB, tails judged numerically below it.
    function automatic logic [3:0] m_sig(input int lb, input int ub, input int s);
        int sh = (STAGES - 1 - s) * CW;
        int m  = 1 << sh;
        m_sig[3] = ((lb >> (sh + CW)) == (ub >> (sh + CW)));
        m_sig[2] = ((lb % m) == 0);
        m_sig[1] = ((ub % m) == m - 1);
        m_sig[0] = (s == STAGES - 1);
    endfunction

    task automatic chk_beat(input int lb, input int ub, input int s);
        int sh = (STAGES - 1 - s) * CW;
        chk("out_valid", out_valid, 1);
        chk("out_stage", out_stage, s);
        chk("out_lbs",   out_lbs, (lb >> sh) & 'hF);
        chk("out_ubs",   out_ubs, (ub >> sh) & 'hF);
        chk("out_sig",   out_sig, m_sig(lb, ub, s));
        chk("out_last",  out_last, s == STAGES - 1);
        chk("out_id",    out_id, model_id);
        chk("err_beat",  err, 0);
    endtask

    task automatic run_rule(input int lb, input int ub, input int stall_s, input int stall_n);
        int t0;
        chk("in_ready_idle", in_ready, 1);
        in_lb = W'(lb); in_ub = W'(ub); in_valid = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            chk("in_ready_emit", in_ready, 0);
            chk_beat(lb, ub, s);
            if (s == stall_s && stall_n > 0) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    chk_beat(lb, ub, s);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        if (stall_n == 0) chk("rule_cycles", cyc - t0, STAGES + 1);
        model_id = (model_id + 1) % 256;
    endtask

    task automatic reject(input int lb, input int ub);
        in_lb = W'(lb); in_ub = W'(ub); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_no_valid", out_valid, 0);
        chk("err_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("err_cleared", err, 0);
        chk("err_no_valid2", out_valid, 0);
    endtask

    initial begin
        int a, b;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_lb = '0; in_ub = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_data", {out_stage, out_lbs, out_ubs, out_sig, out_last, out_id}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        reject('h0010, 'h000F);
        run_rule('h1200, 'h12FF, -1, 0);
        run_rule('hABCD, 'hABCD, -1, 0);
        run_rule('h0000, 'hFFFF, 1, 3);

        // Reset in the middle of the stage-2 beat
        in_lb = 'h3456; in_ub = 'h789A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk_beat('h3456, 'h789A, 2);
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_id", out_id, 0);
        #2 rst = 1'b1;
        model_id = 0;
        @(posedge clk); #1;
        chk("midrst_no_resume", out_valid, 0);
        run_rule('h0100, 'h0200, -1, 0);

        // Random legal rules with random stalls, interleaved with rejects
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 'hFFFF);
            b = $urandom_range(0, 'hFFFF);
            if (i % 7 == 3 && a != b) reject((a > b) ? a : b, (a > b) ? b : a);
            else run_rule((a < b) ? a : b, (a < b) ? b : a, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // 257 back-to-back rules from reset to see the id wrap
        rst = 1'b0; #3 rst = 1'b1; model_id = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 257; i++) begin
            a = $urandom_range(0, 'hFFFF);
            b = $urandom_range(0, 'hFFFF);
            run_rule((a < b) ? a : b, (a < b) ? b : a, -1, 0);
        end
        chk("id_wrapped", model_id, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
